conv3x3_rgb888: RTL and testbench

CONV3X3_RGB888 -- requirements
Module: conv3x3_rgb888

---
 rtl/conv3x3_rgb888_pkg.sv | 38 +++
 rtl/conv3x3_mac_ch.sv | 52 +++++
 rtl/conv3x3_rgb888.sv | 165 ++++++++++++++++
 tb/tb_conv3x3_rgb888.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv3x3_rgb888_pkg.sv
// Shared constants for the 3x3 RGB888 convolution block.
// Byte positions, coefficient indices, reset kernel, datapath widths.
package conv3x3_rgb888_pkg;

    localparam int CH_W   = 8;
    localparam int R_LSB  = 16;
    localparam int G_LSB  = 8;
    localparam int B_LSB  = 0;

    localparam int NTAPS  = 9;
    localparam int PROD_W = 17;
    localparam int SUM_W  = 21;

    localparam logic [3:0] IDX_SHIFT  = 4'd9;
    localparam int         CENTER_TAP = 4;

    localparam logic [7:0] TAP_RST_CTR = 8'd1;
    localparam logic [7:0] TAP_RST_OTH = 8'd0;
    localparam logic [3:0] SHIFT_RST   = 4'd0;

    // Nine bytes: one channel of a window, or the nine signed taps.
    typedef logic [NTAPS-1:0][CH_W-1:0] chan_win_t;

    // Saturate a signed accumulator to the 0..255 pixel range.
    function automatic logic [CH_W-1:0] clamp_u8(
        input logic signed [SUM_W-1:0] v
    );
        logic [CH_W-1:0] r;
        if (v[SUM_W-1])
            r = '0;
        else if (|v[SUM_W-2:CH_W])
            r = '1;
        else
            r = v[CH_W-1:0];
        return r;
    endfunction

endpackage

// File: rtl/conv3x3_mac_ch.sv
// One-channel 3x3 multiply/accumulate/shift/clamp datapath (S1..S3).
// Ports: iClk, iRst (async low), iAdv enable, iPix/iTap windows, iShift, oPix.
module conv3x3_mac_ch
    import conv3x3_rgb888_pkg::*;
(
    input  logic            iClk,
    input  logic            iRst,
    input  logic            iAdv,
    input  chan_win_t       iPix,
    input  chan_win_t       iTap,
    input  logic [3:0]      iShift,
    output logic [CH_W-1:0] oPix
);

    logic signed [PROD_W-1:0] w_prod [NTAPS];
    logic signed [PROD_W-1:0] r_prod [NTAPS];
    logic signed [SUM_W-1:0]  w_sum;
    logic signed [SUM_W-1:0]  w_shr;
    logic signed [SUM_W-1:0]  r_sum;

    // Pixel is zero-extended, tap sign-extended, so the product is exact.
    always_comb begin
        for (int k = 0; k < NTAPS; k++) begin
            w_prod[k] = $signed({9'd0, iPix[k]})
                      * $signed({{9{iTap[k][CH_W-1]}}, iTap[k]});
        end
    end

    always_comb begin
        w_sum = '0;
        for (int k = 0; k < NTAPS; k++) begin
            w_sum = w_sum
                  + $signed({{(SUM_W-PROD_W){r_prod[k][PROD_W-1]}},
                             r_prod[k]});
        end
    end

    assign w_shr = r_sum >>> iShift;

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            for (int k = 0; k < NTAPS; k++) r_prod[k] <= '0;
            r_sum <= '0;
            oPix  <= '0;
        end else if (iAdv) begin
            for (int k = 0; k < NTAPS; k++) r_prod[k] <= w_prod[k];
            r_sum <= w_sum;
            oPix  <= clamp_u8(w_shr);
        end
    end

endmodule

// File: rtl/conv3x3_rgb888.sv
// 3x3 RGB888 convolution with skid input, stall-able write port, addressing.
// Ports: iClk/iRst, iValid+iWin0..8 in, oBusy, coef write, oWe/oWAddr/oWData.
module conv3x3_rgb888
    import conv3x3_rgb888_pkg::*;
#(
    parameter int DATA_W = 24,
    parameter int ADDR_W = 17,
    parameter int WIDTH  = 480,
    parameter int HEIGHT = 272
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iValid,
    input  logic [DATA_W-1:0] iWin0,
    input  logic [DATA_W-1:0] iWin1,
    input  logic [DATA_W-1:0] iWin2,
    input  logic [DATA_W-1:0] iWin3,
    input  logic [DATA_W-1:0] iWin4,
    input  logic [DATA_W-1:0] iWin5,
    input  logic [DATA_W-1:0] iWin6,
    input  logic [DATA_W-1:0] iWin7,
    input  logic [DATA_W-1:0] iWin8,
    output logic              oBusy,
    input  logic              iCoefWe,
    input  logic [3:0]        iCoefIdx,
    input  logic [7:0]        iCoefData,
    output logic              oWe,
    output logic [ADDR_W-1:0] oWAddr,
    output logic [DATA_W-1:0] oWData,
    input  logic              iWrBusy,
    output logic              oFrameDone,
    output logic              oOvf
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH*HEIGHT-1);

    logic              w_adv;
    logic [DATA_W-1:0] w_win  [NTAPS];
    logic [DATA_W-1:0] w_sel  [NTAPS];
    logic [DATA_W-1:0] r_skid [NTAPS];
    logic              r_skid_vld;
    logic              r_v1;
    logic              r_v2;
    logic              r_we;
    logic              r_ovf;
    logic [ADDR_W-1:0] r_addr;
    chan_win_t         r_tap;
    logic [3:0]        r_shift;
    chan_win_t         w_pix_r;
    chan_win_t         w_pix_g;
    chan_win_t         w_pix_b;
    logic [CH_W-1:0]   w_out_r;
    logic [CH_W-1:0]   w_out_g;
    logic [CH_W-1:0]   w_out_b;

    assign w_adv = !iWrBusy;

    assign w_win[0] = iWin0;
    assign w_win[1] = iWin1;
    assign w_win[2] = iWin2;
    assign w_win[3] = iWin3;
    assign w_win[4] = iWin4;
    assign w_win[5] = iWin5;
    assign w_win[6] = iWin6;
    assign w_win[7] = iWin7;
    assign w_win[8] = iWin8;

    // A held skid entry is always older than the live window.
    always_comb begin
        for (int k = 0; k < NTAPS; k++) begin
            w_sel[k]   = r_skid_vld ? r_skid[k] : w_win[k];
            w_pix_r[k] = w_sel[k][R_LSB +: CH_W];
            w_pix_g[k] = w_sel[k][G_LSB +: CH_W];
            w_pix_b[k] = w_sel[k][B_LSB +: CH_W];
        end
    end

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            r_v1       <= 1'b0;
            r_v2       <= 1'b0;
            r_we       <= 1'b0;
            r_skid_vld <= 1'b0;
            r_ovf      <= 1'b0;
            r_addr     <= '0;
            for (int k = 0; k < NTAPS; k++) r_skid[k] <= '0;
        end else begin
            if (w_adv) begin
                r_v1 <= r_skid_vld | iValid;
                r_v2 <= r_v1;
                r_we <= r_v2;
                if (r_skid_vld) begin
                    r_skid_vld <= iValid;
                    if (iValid) begin
                        for (int k = 0; k < NTAPS; k++)
                            r_skid[k] <= w_win[k];
                    end
                end
            end else if (iValid) begin
                if (!r_skid_vld) begin
                    r_skid_vld <= 1'b1;
                    for (int k = 0; k < NTAPS; k++)
                        r_skid[k] <= w_win[k];
                end else begin
                    r_ovf <= 1'b1;
                end
            end
            if (r_we && w_adv) begin
                r_addr <= (r_addr == LAST_ADDR) ? '0 : r_addr + 1'b1;
            end
        end
    end

    // Coefficients update even while the pipeline is stalled.
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            for (int k = 0; k < NTAPS; k++)
                r_tap[k] <= (k == CENTER_TAP) ? TAP_RST_CTR : TAP_RST_OTH;
            r_shift <= SHIFT_RST;
        end else if (iCoefWe) begin
            if (iCoefIdx < IDX_SHIFT)
                r_tap[iCoefIdx] <= iCoefData;
            else if (iCoefIdx == IDX_SHIFT)
                r_shift <= iCoefData[3:0];
        end
    end

    conv3x3_mac_ch u_mac_r (
        .iClk   (iClk),
        .iRst   (iRst),
        .iAdv   (w_adv),
        .iPix   (w_pix_r),
        .iTap   (r_tap),
        .iShift (r_shift),
        .oPix   (w_out_r)
    );

    conv3x3_mac_ch u_mac_g (
        .iClk   (iClk),
        .iRst   (iRst),
        .iAdv   (w_adv),
        .iPix   (w_pix_g),
        .iTap   (r_tap),
        .iShift (r_shift),
        .oPix   (w_out_g)
    );

    conv3x3_mac_ch u_mac_b (
        .iClk   (iClk),
        .iRst   (iRst),
        .iAdv   (w_adv),
        .iPix   (w_pix_b),
        .iTap   (r_tap),
        .iShift (r_shift),
        .oPix   (w_out_b)
    );

    assign oWe        = r_we;
    assign oWAddr     = r_addr;
    assign oWData     = DATA_W'({w_out_r, w_out_g, w_out_b});
    assign oOvf       = r_ovf;
    assign oBusy      = iWrBusy | r_skid_vld;
    assign oFrameDone = r_we & w_adv & (r_addr == LAST_ADDR);

endmodule

// File: tb/tb_conv3x3_rgb888.sv
// Scoreboard bench for conv3x3_rgb888 on a reduced 12x10 frame.
// Directed windows with hand-computed results; monitor checks every write.
module tb_conv3x3_rgb888;

    localparam int W    = 12;
    localparam int H    = 10;
    localparam int NPIX = W * H;

    logic        iClk = 1'b0;
    logic        iRst;
    logic        iValid;
    logic [23:0] iWin0, iWin1, iWin2, iWin3, iWin4;
    logic [23:0] iWin5, iWin6, iWin7, iWin8;
    logic        oBusy;
    logic        iCoefWe;
    logic [3:0]  iCoefIdx;
    logic [7:0]  iCoefData;
    logic        oWe;
    logic [16:0] oWAddr;
    logic [23:0] oWData;
    logic        iWrBusy;
    logic        oFrameDone;
    logic        oOvf;

    typedef struct {
        int          addr;
        logic [23:0] data;
        logic        fd;
    } exp_t;

    exp_t q[$];
    int   exp_addr = 0;
    int   total = 0;
    int   bad = 0;

    conv3x3_rgb888 #(
        .DATA_W (24),
        .ADDR_W (17),
        .WIDTH  (W),
        .HEIGHT (H)
    ) dut (
        .iClk       (iClk),
        .iRst       (iRst),
        .iValid     (iValid),
        .iWin0      (iWin0),
        .iWin1      (iWin1),
        .iWin2      (iWin2),
        .iWin3      (iWin3),
        .iWin4      (iWin4),
        .iWin5      (iWin5),
        .iWin6      (iWin6),
        .iWin7      (iWin7),
        .iWin8      (iWin8),
        .oBusy      (oBusy),
        .iCoefWe    (iCoefWe),
        .iCoefIdx   (iCoefIdx),
        .iCoefData  (iCoefData),
        .oWe        (oWe),
        .oWAddr     (oWAddr),
        .oWData     (oWData),
        .iWrBusy    (iWrBusy),
        .oFrameDone (oFrameDone),
        .oOvf       (oOvf)
    );

    always #5 iClk = ~iClk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: every accepted write is matched against the queue head.
    always @(negedge iClk) begin
        if (iRst === 1'b1) begin
            if (oWe && !iWrBusy) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write addr=%0d data=%h",
                             oWAddr, oWData);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("wdata", oWData, e.data);
                    chk("waddr", oWAddr, e.addr);
                    chk("fdone", oFrameDone, e.fd);
                end
            end else begin
                chk("fdone_idle", oFrameDone, 0);
            end
        end
    end

    task automatic push_exp(input logic [23:0] d);
        exp_t e;
        e.addr = exp_addr;
        e.data = d;
        e.fd   = (exp_addr == NPIX - 1);
        q.push_back(e);
        exp_addr = (exp_addr == NPIX - 1) ? 0 : exp_addr + 1;
    endtask

    task automatic set_win(input logic [23:0] ctr, input logic [23:0] oth);
        iWin0 = oth; iWin1 = oth; iWin2 = oth; iWin3 = oth;
        iWin4 = ctr;
        iWin5 = oth; iWin6 = oth; iWin7 = oth; iWin8 = oth;
    endtask

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send(input logic [23:0] ctr, input logic [23:0] oth,
                        input logic [23:0] exp);
        set_win(ctr, oth);
        iValid = 1'b1;
        push_exp(exp);
        tick();
        iValid = 1'b0;
    endtask

    task automatic coef(input logic [3:0] idx, input logic [7:0] d);
        iCoefWe   = 1'b1;
        iCoefIdx  = idx;
        iCoefData = d;
        tick();
        iCoefWe   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] va;
        logic [23:0] vb;
        logic [7:0]  b8;
        iRst = 1'b0; iValid = 1'b0; iWrBusy = 1'b0;
        iCoefWe = 1'b0; iCoefIdx = '0; iCoefData = '0;
        set_win(24'h0, 24'h0);
        idle(2);
        chk("rst_we", oWe, 0);
        chk("rst_addr", oWAddr, 0);
        chk("rst_data", oWData, 0);
        chk("rst_fd", oFrameDone, 0);
        chk("rst_ovf", oOvf, 0);
        chk("rst_busy", oBusy, 0);
        iRst = 1'b1;
        idle(2);

        // identity kernel from reset, latency exactly three edges
        set_win(24'h123456, 24'h0A0B0C);
        iValid = 1'b1;
        push_exp(24'h123456);
        tick();
        iValid = 1'b0;
        tick();
        chk("lat_t2_we", oWe, 0);
        tick();
        chk("lat_t3_we", oWe, 1);
        idle(3);
        send(24'h00FF7F, 24'h111111, 24'h00FF7F);
        idle(4);

        // box blur
        for (int k = 0; k < 9; k++) coef(4'(k), 8'd1);
        coef(4'd9, 8'd3);
        send(24'hFF8000, 24'hFF8000, 24'hFF9000);
        send(24'h101010, 24'h101010, 24'h121212);
        idle(4);

        // negative clamp
        for (int k = 0; k < 9; k++) coef(4'(k), 8'd0);
        coef(4'd4, 8'hFF);
        coef(4'd9, 8'd0);
        send(24'h010203, 24'h050505, 24'h000000);
        idle(4);

        // upper clamp boundary 254 / 256 / 510
        coef(4'd4, 8'd2);
        send(24'h7F80FF, 24'h000000, 24'hFEFFFF);
        idle(4);

        // mixed-sign kernel with arithmetic shift of a negative sum
        coef(4'd0, 8'hFF);
        coef(4'd9, 8'd1);
        send(24'h801020, 24'h203010, 24'h700018);
        idle(4);

        // restore identity; out-of-range indices must be ignored
        coef(4'd0, 8'd0);
        coef(4'd9, 8'd0);
        coef(4'd4, 8'd1);
        coef(4'd12, 8'h55);
        coef(4'd15, 8'h07);
        send(24'hABCDEF, 24'h123123, 24'hABCDEF);
        idle(4);

        // stall: A pending on the output, B to skid, C dropped
        send(24'h102030, 24'h0, 24'h102030);
        idle(2);
        chk("stall_pre_we", oWe, 1);
        va = q[0].data;
        vb = 24'h405060;
        iWrBusy = 1'b1;
        set_win(vb, 24'h0);
        iValid = 1'b1;
        push_exp(vb);
        tick();
        chk("stall_busy", oBusy, 1);
        chk("stall_ovf0", oOvf, 0);
        chk("stall_we", oWe, 1);
        chk("stall_dataA", oWData, va);
        set_win(24'h708090, 24'h0);
        iValid = 1'b1;
        tick();
        iValid = 1'b0;
        chk("stall_ovf1", oOvf, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_hold_we", oWe, 1);
            chk("stall_hold_data", oWData, va);
            chk("stall_hold_addr", oWAddr, q[0].addr);
        end
        iWrBusy = 1'b0;
        tick();
        chk("stall_unbusy", oBusy, 0);
        idle(5);
        chk("ovf_sticky", oOvf, 1);

        // stream through the end of the frame and past the wrap
        begin
            int n;
            n = NPIX + 3 - exp_addr;
            for (int i = 0; i < n; i++) begin
                b8 = 8'(i);
                send({b8, ~b8, 8'h5A}, 24'h0, {b8, ~b8, 8'h5A});
            end
        end
        idle(5);
        chk("wrap_addr", oWAddr, 3);

        // mid-frame reset with windows in flight
        for (int i = 0; i < 103; i++) begin
            b8 = 8'(i);
            send({8'h33, b8, b8}, 24'h0, {8'h33, b8, b8});
        end
        iRst = 1'b0;
        q.delete();
        exp_addr = 0;
        #1;
        chk("mrst_we", oWe, 0);
        chk("mrst_addr", oWAddr, 0);
        chk("mrst_data", oWData, 0);
        chk("mrst_fd", oFrameDone, 0);
        chk("mrst_ovf", oOvf, 0);
        tick();
        iRst = 1'b1;
        tick();
        send(24'h5A5A5A, 24'h0, 24'h5A5A5A);
        begin
            int cyc;
            cyc = 0;
            while (q.size() != 0 && cyc < 20) begin
                tick();
                cyc++;
            end
        end
        chk("queue_drained", q.size(), 0);
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
